// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbitration slice.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req at or after ptr, wrapping.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ message sources; owner keeps the port until
// its last byte or MAX_BURST beats, then the grant rotates round-robin.
//
// state | meaning
// ARB   | no owner; pick next requester at or after rr_ptr
// GRANT | grant_id owns the port; beats pass straight through
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                   req_last,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 tx_valid,
  output logic [DATA_WIDTH-1:0]                tx_data,
  input  logic                                 tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;

  rr_picker #(
    .N(NUM_REQ)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    req_ready  = '0;

    case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end

      GRANT: begin
        tx_valid            = req_valid[grant_q];
        tx_data             = req_data[grant_q];
        req_ready[grant_q]  = tx_ready;
        if (req_valid[grant_q] && tx_ready) begin
          // The beat reaching MAX_BURST releases, so the counter never wraps.
          if (req_last[grant_q] || beat_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d    = ARB;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end

      default: state_d = ARB;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the character width, matching the uart_if data width.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of beats per grant before forced release.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester byte valid.
REQ-007 SHALL have port req_data, input, NUM_REQ x DATA_WIDTH bits: per-requester byte.
REQ-008 SHALL have port req_last, input, NUM_REQ bits: marks the final byte of a message.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-010 SHALL have port tx_valid, output, 1 bit: byte valid toward the shared uart_tx.
REQ-011 SHALL have port tx_data, output, DATA_WIDTH bits: byte toward uart_tx.
REQ-012 SHALL have port tx_ready, input, 1 bit: uart_tx accepts the byte.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: the current owner.
REQ-014 SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-015 SHALL implement FSM states ARB and GRANT.
REQ-016 In ARB with any req_valid high, SHALL register the winner into grant_id and enter GRANT next cycle; with none high, SHALL stay in ARB.
REQ-017 SHALL pick the winner round-robin: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-018 In GRANT, tx_valid SHALL be req_valid[grant_id] and tx_data SHALL be req_data[grant_id], both combinational.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal tx_ready; all other req_ready bits SHALL be 0; all req_ready SHALL be 0 in ARB.
REQ-020 A beat SHALL transfer when tx_valid && tx_ready; beat_cnt SHALL increment per beat.
REQ-021 On a beat with req_last[grant_id]=1, or on the beat making beat_cnt equal MAX_BURST, SHALL return to ARB, clear beat_cnt, and set rr_ptr = grant_id+1 mod NUM_REQ.
REQ-022 If the owner drops req_valid mid-message, SHALL hold the grant with tx_valid=0; there is no timeout.
REQ-023 Minimum gap between consecutive grants SHALL be one ARB cycle; single-requester throughput is limited only by tx_ready.
REQ-024 beat_cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap.
REQ-025 tx_valid SHALL NOT deassert once raised until the beat transfers, provided the owner obeys valid/ready.
REQ-026 In ARB, tx_valid SHALL be 0 and tx_data SHALL be 0.

Reset
REQ-027 On rstn low: state=ARB, grant_id=0, rr_ptr=0, beat_cnt=0, busy=0, tx_valid=0, tx_data=0, req_ready=0, taking effect immediately.
REQ-028 Reset asserted mid-message SHALL abandon the message; after release, arbitration SHALL restart from requester 0.

Structure
REQ-029 Package uart_pkg SHALL hold the arb_state_t enum (ARB, GRANT) and the default DATA_WIDTH constant.
REQ-030 SHALL contain one sub-module, rr_picker: combinational round-robin search (req vector and pointer in; index and found out).

Verification
REQ-031 Reset, then req_valid=4'b0001 with a 3-byte message 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> grant_id=0 one cycle later, three beats in consecutive cycles, then ARB.
REQ-032 All four requesters hold single-byte messages -> grants are issued in order 0,1,2,3, then 0 again, each separated by one ARB cycle.
REQ-033 Requester 2 streams 20 bytes with no last, MAX_BURST=16 -> forced release after 16 beats; requester 3 (also valid) is granted next; requester 2 is regranted later and sends the remaining 4 bytes.
REQ-034 Owner valid toggles 1,0,0,1 mid-message with tx_ready=1 -> tx_valid follows the owner, grant is held, and no other req_ready rises.
REQ-035 tx_ready held low for 50 cycles during GRANT -> tx_data is stable, req_ready[grant_id]=0, and no beat is counted.
REQ-036 rstn pulsed low during beat 2 of a 5-byte message -> all outputs return to zero immediately; after release, requester 0 is served first.
